// File: rtl/modn_pkg.sv
// Shared definitions for mod-N counter logic: state encodings and
// modular increment/decrement helpers.
package modn_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_UP    = 2'd1;
  localparam logic [1:0] ST_DOWN  = 2'd2;
  localparam logic [1:0] ST_STALL = 2'd3;

  function automatic int unsigned modn_inc(input int unsigned v, input int unsigned n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

  function automatic int unsigned modn_dec(input int unsigned v, input int unsigned n);
    return (v == 0) ? n - 1 : v - 1;
  endfunction

endpackage

// File: rtl/modn_step_classify.sv
// Combinational classifier of a count transition p -> s on a mod-N bus.
module modn_step_classify
  import modn_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] s,
  output logic         up,
  output logic         down,
  output logic         hold,
  output logic         illegal,
  output logic         wrap_up,
  output logic         wrap_dn,
  output logic         in_range
);

  logic [31:0] p_i;
  logic [31:0] s_i;

  assign p_i = 32'(p);
  assign s_i = 32'(s);

  always_comb begin
    in_range = (s_i < N);
    up       = in_range && (s_i == modn_inc(p_i, N));
    down     = in_range && (s_i == modn_dec(p_i, N));
    hold     = in_range && (s_i == p_i);
    illegal  = !(up || down || hold);
    wrap_up  = up && (p_i == N - 1) && (s_i == 0);
    wrap_dn  = down && (p_i == 0) && (s_i == N - 1);
  end

endmodule

// File: rtl/modn_count_decoder.sv
// Monitor for a mod-N up/down counter bus: recovers direction, wraps,
// reversals and stalls, and flags illegal transitions.
module modn_count_decoder
  import modn_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned W          = $clog2(N),
  parameter int unsigned HOLD_LIMIT = 8,
  parameter int unsigned SC_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [W-1:0]    count_in,
  input  logic            clr_err,
  output logic [1:0]      state,
  output logic            dir_out,
  output logic            dir_valid,
  output logic            wrap_up,
  output logic            wrap_dn,
  output logic            rev_pulse,
  output logic            err_pulse,
  output logic            err_sticky,
  output logic [SC_W-1:0] step_cnt
);

  localparam int unsigned HW = $clog2(HOLD_LIMIT + 1);

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    prev_q, prev_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            dir_q, dir_d;
  logic            dv_q, dv_d;
  logic            wrap_up_q, wrap_up_d;
  logic            wrap_dn_q, wrap_dn_d;
  logic            rev_q, rev_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;
  logic [SC_W-1:0] step_q, step_d;

  logic c_up, c_down, c_hold, c_illegal, c_wrap_up, c_wrap_dn, c_in_range;

  modn_step_classify #(
    .N (N),
    .W (W)
  ) u_classify (
    .p        (prev_q),
    .s        (count_in),
    .up       (c_up),
    .down     (c_down),
    .hold     (c_hold),
    .illegal  (c_illegal),
    .wrap_up  (c_wrap_up),
    .wrap_dn  (c_wrap_dn),
    .in_range (c_in_range)
  );

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    hold_d    = hold_q;
    dir_d     = dir_q;
    dv_d      = dv_q;
    step_d    = step_q;
    wrap_up_d = 1'b0;
    wrap_dn_d = 1'b0;
    rev_d     = 1'b0;
    err_d     = 1'b0;
    // Set wins over clear: a new error below overrides this.
    sticky_d  = sticky_q & ~clr_err;

    if (valid_in) begin
      if (state_q == ST_INIT) begin
        if (c_in_range) begin
          prev_d  = count_in;
          state_d = ST_STALL;
          hold_d  = '0;
          dv_d    = 1'b0;
        end else begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
        end
      end else if (c_illegal) begin
        err_d    = 1'b1;
        sticky_d = 1'b1;
        state_d  = ST_INIT;
        hold_d   = '0;
        dv_d     = 1'b0;
      end else if (c_up || c_down) begin
        prev_d    = count_in;
        hold_d    = '0;
        dir_d     = c_up;
        dv_d      = 1'b1;
        state_d   = c_up ? ST_UP : ST_DOWN;
        wrap_up_d = c_wrap_up;
        wrap_dn_d = c_wrap_dn;
        // Reversal only between two directional states, never out of STALL.
        rev_d     = ((state_q == ST_UP) && c_down) || ((state_q == ST_DOWN) && c_up);
        if (step_q != '1) step_d = step_q + 1'b1;
      end else if (c_hold) begin
        if (hold_q != HW'(HOLD_LIMIT)) hold_d = hold_q + 1'b1;
        if (hold_d == HW'(HOLD_LIMIT)) begin
          state_d = ST_STALL;
          dv_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      prev_q    <= '0;
      hold_q    <= '0;
      dir_q     <= 1'b0;
      dv_q      <= 1'b0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      rev_q     <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      hold_q    <= hold_d;
      dir_q     <= dir_d;
      dv_q      <= dv_d;
      wrap_up_q <= wrap_up_d;
      wrap_dn_q <= wrap_dn_d;
      rev_q     <= rev_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      step_q    <= step_d;
    end
  end

  assign state      = state_q;
  assign dir_out    = dir_q;
  assign dir_valid  = dv_q;
  assign wrap_up    = wrap_up_q;
  assign wrap_dn    = wrap_dn_q;
  assign rev_pulse  = rev_q;
  assign err_pulse  = err_q;
  assign err_sticky = sticky_q;
  assign step_cnt   = step_q;

endmodule

// File: tb/tb_modn_count_decoder.sv
// Directed self-checking bench: N=16 instance for the main scenarios,
// N=10 / SC_W=4 instance for out-of-range samples and step_cnt saturation.
module tb_modn_count_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: N=16
  logic        a_rst = 1'b0, a_valid = 1'b0, a_clr = 1'b0;
  logic [3:0]  a_count = '0;
  logic [1:0]  a_state;
  logic        a_dir, a_dv, a_wu, a_wd, a_rev, a_err, a_sticky;
  logic [15:0] a_step;

  modn_count_decoder #(.N(16), .W(4), .HOLD_LIMIT(8), .SC_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .valid_in(a_valid), .count_in(a_count), .clr_err(a_clr),
    .state(a_state), .dir_out(a_dir), .dir_valid(a_dv), .wrap_up(a_wu), .wrap_dn(a_wd),
    .rev_pulse(a_rev), .err_pulse(a_err), .err_sticky(a_sticky), .step_cnt(a_step)
  );

  // Instance B: N=10, 4-bit saturating step counter
  logic        b_rst = 1'b0, b_valid = 1'b0, b_clr = 1'b0;
  logic [3:0]  b_count = '0;
  logic [1:0]  b_state;
  logic        b_dir, b_dv, b_wu, b_wd, b_rev, b_err, b_sticky;
  logic [3:0]  b_step;

  modn_count_decoder #(.N(10), .W(4), .HOLD_LIMIT(3), .SC_W(4)) dut_b (
    .clk(clk), .rst(b_rst), .valid_in(b_valid), .count_in(b_count), .clr_err(b_clr),
    .state(b_state), .dir_out(b_dir), .dir_valid(b_dv), .wrap_up(b_wu), .wrap_dn(b_wd),
    .rev_pulse(b_rev), .err_pulse(b_err), .err_sticky(b_sticky), .step_cnt(b_step)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on A; outputs are examined 1 time unit after the edge.
  task automatic cyc_a(input logic v, input logic [3:0] s, input logic clr);
    @(negedge clk);
    a_valid = v; a_count = s; a_clr = clr;
    @(posedge clk); #1;
    a_valid = 1'b0; a_clr = 1'b0;
  endtask

  task automatic smp_a(input logic [3:0] s);
    cyc_a(1'b1, s, 1'b0);
  endtask

  task automatic reset_a();
    @(negedge clk); a_rst = 1'b1; a_valid = 1'b0;
    @(posedge clk); #1; a_rst = 1'b0;
  endtask

  task automatic smp_b(input logic [3:0] s);
    @(negedge clk); b_valid = 1'b1; b_count = s;
    @(posedge clk); #1; b_valid = 1'b0;
  endtask

  initial begin
    // ---------- Reset state ----------
    reset_a();
    chk("rst_state", a_state, 0);
    chk("rst_dir", a_dir, 0);
    chk("rst_dv", a_dv, 0);
    chk("rst_step", a_step, 0);
    chk("rst_sticky", a_sticky, 0);
    chk("rst_err", a_err, 0);

    // ---------- Up count 0..15,0 with wrap ----------
    smp_a(4'd0);
    chk("up_init_state", a_state, 3);
    chk("up_init_dv", a_dv, 0);
    smp_a(4'd1);
    chk("up_state", a_state, 1);
    chk("up_dir", a_dir, 1);
    chk("up_dv", a_dv, 1);
    for (int i = 2; i < 16; i++) smp_a(4'(i));
    chk("up_no_early_wrap", a_wu, 0);
    chk("up_step15", a_step, 15);
    smp_a(4'd0);
    chk("up_wrap", a_wu, 1);
    chk("up_wrap_nodn", a_wd, 0);
    chk("up_step16", a_step, 16);
    cyc_a(1'b0, 4'd7, 1'b0);
    chk("up_wrap_once", a_wu, 0);
    chk("idle_state", a_state, 1);
    chk("idle_step", a_step, 16);

    // ---------- Down count 3,2,1,0,15,14 ----------
    reset_a();
    smp_a(4'd3);
    smp_a(4'd2);
    chk("dn_state", a_state, 2);
    chk("dn_dir", a_dir, 0);
    smp_a(4'd1);
    smp_a(4'd0);
    chk("dn_no_early_wrap", a_wd, 0);
    smp_a(4'd15);
    chk("dn_wrap", a_wd, 1);
    chk("dn_no_rev", a_rev, 0);
    smp_a(4'd14);
    chk("dn_wrap_once", a_wd, 0);
    chk("dn_step5", a_step, 5);

    // ---------- Reversal 5,6,7,6 ----------
    reset_a();
    smp_a(4'd5);
    smp_a(4'd6);
    smp_a(4'd7);
    chk("rev_none_yet", a_rev, 0);
    smp_a(4'd6);
    chk("rev_pulse", a_rev, 1);
    chk("rev_state", a_state, 2);
    chk("rev_dir", a_dir, 0);
    cyc_a(1'b0, 4'd6, 1'b0);
    chk("rev_once", a_rev, 0);

    // ---------- Stall after 8 holds, then step out of STALL ----------
    reset_a();
    smp_a(4'd4);
    smp_a(4'd5);
    for (int i = 0; i < 7; i++) smp_a(4'd5);
    chk("hold7_state", a_state, 1);
    chk("hold7_dv", a_dv, 1);
    cyc_a(1'b0, 4'd9, 1'b0);
    chk("hold_idle_state", a_state, 1);
    smp_a(4'd5);
    chk("stall_state", a_state, 3);
    chk("stall_dv", a_dv, 0);
    chk("stall_dir", a_dir, 1);
    smp_a(4'd4);
    chk("unstall_state", a_state, 2);
    chk("unstall_no_rev", a_rev, 0);
    chk("unstall_dir", a_dir, 0);

    // ---------- Illegal jump, resync, clr_err ----------
    reset_a();
    smp_a(4'd2);
    smp_a(4'd3);
    smp_a(4'd9);
    chk("ill_err", a_err, 1);
    chk("ill_sticky", a_sticky, 1);
    chk("ill_state", a_state, 0);
    chk("ill_dir_kept", a_dir, 1);
    chk("ill_step_kept", a_step, 1);
    chk("ill_no_wrap", a_wu, 0);
    cyc_a(1'b0, 4'd0, 1'b0);
    chk("ill_err_once", a_err, 0);
    chk("ill_sticky_hold", a_sticky, 1);
    smp_a(4'd9);
    chk("resync_state", a_state, 3);
    smp_a(4'd10);
    chk("resync_up", a_state, 1);
    chk("resync_step", a_step, 2);
    cyc_a(1'b1, 4'd3, 1'b1);
    chk("clr_vs_err_err", a_err, 1);
    chk("clr_vs_err_sticky", a_sticky, 1);
    cyc_a(1'b0, 4'd0, 1'b1);
    chk("clr_sticky", a_sticky, 0);

    // ---------- Mid-stream reset with valid_in=1 ----------
    reset_a();
    smp_a(4'd0);
    smp_a(4'd1);
    smp_a(4'd2);
    @(negedge clk); a_rst = 1'b1; a_valid = 1'b1; a_count = 4'd3;
    @(posedge clk); #1; a_rst = 1'b0; a_valid = 1'b0;
    chk("mrst_state", a_state, 0);
    chk("mrst_dir", a_dir, 0);
    chk("mrst_dv", a_dv, 0);
    chk("mrst_step", a_step, 0);
    chk("mrst_pulses", {a_wu, a_wd, a_rev, a_err, a_sticky}, 0);

    // ---------- Instance B: out-of-range and saturation ----------
    @(negedge clk); b_rst = 1'b1;
    @(posedge clk); #1; b_rst = 1'b0;
    smp_b(4'd12);
    chk("b_oor_init_err", b_err, 1);
    chk("b_oor_init_state", b_state, 0);
    smp_b(4'd0);
    chk("b_init_ok", b_state, 3);
    for (int i = 1; i < 10; i++) smp_b(4'(i));
    smp_b(4'd0);
    chk("b_wrap_n10", b_wu, 1);
    chk("b_step10", b_step, 10);
    for (int i = 1; i < 10; i++) smp_b(4'(i));
    chk("b_step_sat", b_step, 15);
    smp_b(4'd10);
    chk("b_oor_err", b_err, 1);
    chk("b_oor_state", b_state, 0);
    chk("b_oor_step_kept", b_step, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
